// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag/data widths, the "no tag" label,
// and functional-unit indices used by the CDB requesters.
package tomasulo_pkg;

    localparam int LABEL_W = 5;
    localparam int DATA_W  = 32;

    localparam logic [LABEL_W-1:0] NO_LABEL = 5'd0;

    localparam int FU_ALU = 0;
    localparam int FU_LS  = 1;
    localparam int FU_MUL = 2;
    localparam int FU_DIV = 3;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between functional units and the CDB arbiter.
// master = arbiter side, slave = requesters/consumers side.
interface cdb_arbiter_if
    import tomasulo_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DATA_W,
    parameter int LW   = LABEL_W
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*LW-1:0] req_label;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               BCEN;
    logic [LW-1:0]      BClabel;
    logic [DW-1:0]      BCdata;
    logic [2:0]         grant_id;

    modport master (
        input  req_valid, req_label, req_data,
        output req_ready, BCEN, BClabel, BCdata, grant_id
    );

    modport slave (
        output req_valid, req_label, req_data,
        input  req_ready, BCEN, BClabel, BCdata, grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr_i is bit 0,
// take the lowest set bit, then rotate the winner back to absolute index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0]  rot;
    logic [IW-1:0] pos;
    logic [IW:0]   sum;

    // Rotate, priority-encode, rotate back.
    always_comb begin
        rot = N'({req_i, req_i} >> ptr_i);
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pos = IW'(i);
        end
        any_o = |rot;
        sum = {1'b0, pos} + {1'b0, ptr_i};
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        idx_o = sum[IW-1:0];
        gnt_o = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one round-robin winner per cycle, registered
// BCEN/BClabel/BCdata broadcast. Optional counters under CDB_STATS_EN.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DATA_W,
    parameter int LW   = LABEL_W
) (
    input  logic         clk,
    input  logic         nRST,
    cdb_arbiter_if.master bus
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]  bc_count,
    output logic [31:0]  conflict_count
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   idx;
    logic            any;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            bcen_q, bcen_d;
    logic [LW-1:0]   label_q, label_d;
    logic [DW-1:0]   data_q, data_d;
    logic [IW-1:0]   gid_q, gid_d;

    // Label-0 requests are protocol errors; they are simply skipped.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req_valid[i] &&
                      (bus.req_label[i*LW +: LW] != LW'(NO_LABEL));
        end
    end

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (idx),
        .any_o (any)
    );

    assign bus.req_ready = nRST ? gnt : '0;

    // Next broadcast and pointer; idle cycles broadcast zeros.
    always_comb begin
        bcen_d  = any;
        label_d = any ? bus.req_label[idx*LW +: LW] : '0;
        data_d  = any ? bus.req_data[idx*DW +: DW] : '0;
        gid_d   = any ? idx : '0;
        ptr_d   = ptr_q;
        if (any) begin
            ptr_d = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Broadcast register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            bcen_q  <= 1'b0;
            label_q <= '0;
            data_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
        end else begin
            bcen_q  <= bcen_d;
            label_q <= label_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.BCEN     = bcen_q;
    assign bus.BClabel  = label_q;
    assign bus.BCdata   = data_q;
    assign bus.grant_id = 3'(gid_q);

`ifdef CDB_STATS_EN
    logic conflict;

    assign conflict = $countones(elig) > 1;

    // Saturating counters; bc_count steps on the edge BCEN rises for a grant.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            bc_count       <= '0;
            conflict_count <= '0;
        end else begin
            if (bcen_d && bc_count != '1) begin
                bc_count <= bc_count + 1'b1;
            end
            if (conflict && conflict_count != '1) begin
                conflict_count <= conflict_count + 1'b1;
            end
        end
    end
`endif

endmodule
